// File: rtl/semiauto_nav.sv
// ---------------------------------------------------------------------------
// semiauto_nav : semi-automatic crossroad navigation controller for the car
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module semiauto_nav #(
  parameter int                 NUM_DET      = 4,
  parameter logic [NUM_DET-1:0] DET_MASK     = NUM_DET'(4'b0111),
  parameter logic [NUM_DET-1:0] DET_POL      = NUM_DET'(4'b0110),
  parameter int                 TICK_DIV     = 2000000,
  parameter int                 TURN_TICKS   = 45,
  parameter int                 AROUND_TICKS = 90,
  parameter int                 COOL_TICKS   = 50,
  parameter int                 CNT_W        = 11
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               power,
  input  logic [1:0]         global_state,
  input  logic [NUM_DET-1:0] detector,
  input  logic               turn_left,
  input  logic               turn_right,
  input  logic               go_straight,
  input  logic               go_back,
  output logic [1:0]         state,
  output logic [3:0]         moving_state,
  output logic               move_forward_light,
  output logic               move_backward_light,
  output logic               turn_left_light,
  output logic               turn_right_light
);

  typedef enum logic [1:0] {
    ST_FORWARD = 2'b00,
    ST_WAIT    = 2'b01,
    ST_TURN    = 2'b10,
    ST_COOL    = 2'b11
  } state_e;

  localparam logic [3:0] MV_STOP  = 4'b0000;
  localparam logic [3:0] MV_FWD   = 4'b0001;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  localparam int               PRE_W       = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] AROUND_LAST = CNT_W'(AROUND_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOL_TICKS - 1);

  state_e           state_q, state_d;
  logic [3:0]       mv_q, mv_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             around_q, around_d;
  logic             armed_q, armed_d;
  logic             fwd_lt_q, fwd_lt_d;
  logic             back_lt_q, back_lt_d;
  logic             left_lt_q, left_lt_d;
  logic             right_lt_q, right_lt_d;

  logic             enable;
  logic             crossroad;
  logic             tick;
  logic             any_cmd;
  logic [CNT_W-1:0] turn_last;
  logic             turn_done;
  logic             cool_done;

  assign enable    = power & ((global_state == 2'b01) | (global_state == 2'b10));
  assign crossroad = |((detector ^ DET_POL) & DET_MASK);
  assign tick      = (pre_q == PRE_LAST);
  assign any_cmd   = turn_left | turn_right | go_straight | go_back;
  assign turn_last = around_q ? AROUND_LAST : TURN_LAST;
  assign turn_done = tick & (cnt_q == turn_last);
  assign cool_done = tick & (cnt_q == COOL_LAST);

  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    around_d = around_q;
    armed_d  = armed_q;

    unique case (state_q)
      ST_FORWARD: begin
        mv_d = MV_FWD;
        if (crossroad) begin
          state_d = ST_WAIT;
          mv_d    = MV_STOP;
        end
      end
      ST_WAIT: begin
        mv_d = MV_STOP;
        if (!any_cmd) begin
          armed_d = 1'b1;
        end
        if (armed_q) begin
          if (go_straight) begin
            state_d = ST_COOL;
            mv_d    = MV_FWD;
          end else if (go_back) begin
            state_d  = ST_TURN;
            mv_d     = MV_RIGHT;
            around_d = 1'b1;
          end else if (turn_left & ~turn_right) begin
            state_d = ST_TURN;
            mv_d    = MV_LEFT;
          end else if (turn_right & ~turn_left) begin
            state_d = ST_TURN;
            mv_d    = MV_RIGHT;
          end
        end
      end
      ST_TURN: begin
        if (turn_done) begin
          state_d  = ST_WAIT;
          mv_d     = MV_STOP;
          around_d = 1'b0;
        end
      end
      ST_COOL: begin
        mv_d = MV_FWD;
        if (cool_done) begin
          state_d = ST_FORWARD;
        end
      end
      default: begin
        state_d = ST_WAIT;
        mv_d    = MV_STOP;
      end
    endcase

    // The interlock is only meaningful while parked; any exit disarms it.
    if (state_d != ST_WAIT) begin
      armed_d = 1'b0;
    end

    if (!enable) begin
      state_d  = ST_WAIT;
      mv_d     = MV_STOP;
      around_d = 1'b0;
      armed_d  = 1'b0;
    end
  end

  // Timebase restarts on every state entry so timed states last exactly N ticks.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!enable || (state_d != state_q)) begin
      pre_d = '0;
      cnt_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick && ((state_q == ST_TURN) || (state_q == ST_COOL))) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    fwd_lt_d   = (mv_d == MV_FWD);
    left_lt_d  = (mv_d == MV_LEFT);
    right_lt_d = (mv_d == MV_RIGHT);
    back_lt_d  = (state_d == ST_TURN) & around_d;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_WAIT;
      mv_q       <= MV_STOP;
      pre_q      <= '0;
      cnt_q      <= '0;
      around_q   <= 1'b0;
      armed_q    <= 1'b0;
      fwd_lt_q   <= 1'b0;
      back_lt_q  <= 1'b0;
      left_lt_q  <= 1'b0;
      right_lt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_q       <= mv_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      around_q   <= around_d;
      armed_q    <= armed_d;
      fwd_lt_q   <= fwd_lt_d;
      back_lt_q  <= back_lt_d;
      left_lt_q  <= left_lt_d;
      right_lt_q <= right_lt_d;
    end
  end

  assign state               = state_q;
  assign moving_state        = mv_q;
  assign move_forward_light  = fwd_lt_q;
  assign move_backward_light = back_lt_q;
  assign turn_left_light     = left_lt_q;
  assign turn_right_light    = right_lt_q;

endmodule

`default_nettype wire

// File: tb/tb_semiauto_nav.sv
// ---------------------------------------------------------------------------
// tb_semiauto_nav : directed bench with a cycle-level behavioural car model
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_semiauto_nav;

  localparam int TICK_DIV     = 4;
  localparam int TURN_TICKS   = 3;
  localparam int AROUND_TICKS = 6;
  localparam int COOL_TICKS   = 2;
  localparam logic [3:0] MASK = 4'b0111;
  localparam logic [3:0] POL  = 4'b0110;

  localparam int S_FWD  = 0;
  localparam int S_WAIT = 1;
  localparam int S_TURN = 2;
  localparam int S_COOL = 3;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       power = 1'b0;
  logic [1:0] global_state = 2'b00;
  logic [3:0] detector = 4'b0110;
  logic       turn_left = 1'b0;
  logic       turn_right = 1'b0;
  logic       go_straight = 1'b0;
  logic       go_back = 1'b0;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic       move_forward_light, move_backward_light, turn_left_light, turn_right_light;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;
  int n;

  semiauto_nav #(
    .NUM_DET(4), .DET_MASK(MASK), .DET_POL(POL), .TICK_DIV(TICK_DIV),
    .TURN_TICKS(TURN_TICKS), .AROUND_TICKS(AROUND_TICKS),
    .COOL_TICKS(COOL_TICKS), .CNT_W(11)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .power(power), .global_state(global_state),
    .detector(detector), .turn_left(turn_left), .turn_right(turn_right),
    .go_straight(go_straight), .go_back(go_back), .state(state),
    .moving_state(moving_state), .move_forward_light(move_forward_light),
    .move_backward_light(move_backward_light), .turn_left_light(turn_left_light),
    .turn_right_light(turn_right_light)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: timed states hold a remaining-cycle budget rather than a tick counter.
  int         m_st = S_WAIT;
  int         m_rem = 0;
  logic [3:0] m_mv = 4'b0000;
  bit         m_around = 1'b0;
  bit         m_armed = 1'b0;
  bit         m_en, m_cross;

  always_comb begin
    m_en    = power && (global_state == 2'b01 || global_state == 2'b10);
    m_cross = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (MASK[i] && (POL[i] ? (detector[i] == 1'b0) : (detector[i] == 1'b1))) m_cross = 1'b1;
    end
  end

  always @(posedge sys_clk or negedge rst) begin
    if (!rst || !m_en) begin
      m_st <= S_WAIT; m_mv <= 4'b0000; m_around <= 1'b0; m_armed <= 1'b0; m_rem <= 0;
    end else begin
      case (m_st)
        S_FWD: if (m_cross) begin m_st <= S_WAIT; m_mv <= 4'b0000; end
        S_WAIT: begin
          if (m_armed && go_straight) begin
            m_st <= S_COOL; m_mv <= 4'b0001; m_rem <= TICK_DIV * COOL_TICKS; m_armed <= 1'b0;
          end else if (m_armed && go_back) begin
            m_st <= S_TURN; m_mv <= 4'b1000; m_around <= 1'b1;
            m_rem <= TICK_DIV * AROUND_TICKS; m_armed <= 1'b0;
          end else if (m_armed && turn_left && !turn_right) begin
            m_st <= S_TURN; m_mv <= 4'b0100; m_rem <= TICK_DIV * TURN_TICKS; m_armed <= 1'b0;
          end else if (m_armed && turn_right && !turn_left) begin
            m_st <= S_TURN; m_mv <= 4'b1000; m_rem <= TICK_DIV * TURN_TICKS; m_armed <= 1'b0;
          end else if (!(turn_left || turn_right || go_straight || go_back)) begin
            m_armed <= 1'b1;
          end
        end
        S_TURN: begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin m_st <= S_WAIT; m_mv <= 4'b0000; m_around <= 1'b0; end
        end
        default: begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_st <= S_FWD;
        end
      endcase
    end
  end

  task automatic step();
    logic [9:0] dut_v, exp_v;
    @(negedge sys_clk);
    if (check_en) begin
      dut_v = {state, moving_state, move_forward_light, move_backward_light,
               turn_left_light, turn_right_light};
      exp_v = {2'(m_st), m_mv, m_mv == 4'b0001, (m_st == S_TURN) && m_around,
               m_mv == 4'b0100, m_mv == 4'b1000};
      n_total++;
      if (dut_v === exp_v) n_pass++;
      else $display("FAIL cycle_cmp t=%0t dut=%b model=%b", $time, dut_v, exp_v);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  task automatic measure(input logic [1:0] st, input int bound, output int cnt);
    cnt = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (state != st) return;
      cnt++;
    end
    n_total++;
    $display("FAIL measure_timeout state=%0d cycles=%0d bound=%0d", st, cnt, bound);
  endtask

  function automatic logic [3:0] lights();
    return {move_forward_light, move_backward_light, turn_left_light, turn_right_light};
  endfunction

  initial begin
    repeat (2) step();
    check_en = 1'b1;
    step();
    chk("reset_state", {26'd0, state, moving_state}, {26'd0, 2'b01, 4'b0000});
    chk("reset_lights", {28'd0, lights()}, 32'd0);

    // enabled but idle: parks in WAIT until a command
    #1 rst = 1'b1; power = 1'b1; global_state = 2'b01;
    step(); step();
    chk("hold_wait", {30'd0, state}, 32'd1);
    #1 go_straight = 1'b1;
    measure(2'b11, 50, n);
    chk("cool_len", n, 8);
    #1 go_straight = 1'b0;
    chk("forward_after_cool", {27'd0, state, move_forward_light}, {27'd0, 2'b00, 1'b1});

    // crossroad then a pulsed left turn
    #1 detector = 4'b0100;
    step();
    chk("crossroad_wait", {26'd0, state, moving_state}, {26'd0, 2'b01, 4'b0000});
    #1 detector = 4'b0110;
    step();
    #1 turn_left = 1'b1;
    step();
    chk("left_start", {25'd0, state, moving_state, turn_left_light}, {25'd0, 2'b10, 4'b0100, 1'b1});
    #1 turn_left = 1'b0;
    measure(2'b10, 50, n);
    chk("left_len", n + 1, 12);

    // held button: one turn only, no retrigger
    step();
    #1 turn_left = 1'b1;
    measure(2'b10, 50, n);
    chk("held_left_len", n, 12);
    repeat (4) step();
    chk("held_no_retrigger", {30'd0, state}, 32'd1);
    #1 turn_left = 1'b0;
    step();
    #1 go_back = 1'b1;
    step();
    chk("about_start", {24'd0, state, moving_state, move_backward_light, turn_right_light},
        {24'd0, 2'b10, 4'b1000, 1'b1, 1'b1});
    #1 go_back = 1'b0;
    measure(2'b10, 60, n);
    chk("about_len", n + 1, 24);

    // left+right together is ignored; go_straight wins over them
    #1 global_state = 2'b10;
    step();
    #1 turn_left = 1'b1; turn_right = 1'b1;
    repeat (3) step();
    chk("left_right_ignored", {26'd0, state, moving_state}, {26'd0, 2'b01, 4'b0000});
    #1 go_straight = 1'b1;
    step();
    chk("straight_priority", {30'd0, state}, 32'd3);
    #1 go_straight = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
    measure(2'b11, 50, n);
    chk("cool_len2", n + 1, 8);

    // power drop mid-turn aborts; restore requires release before new command
    #1 detector = 4'b0100;
    step();
    #1 detector = 4'b0110;
    step();
    #1 turn_right = 1'b1;
    step();
    chk("right_start", {25'd0, state, moving_state, move_backward_light}, {25'd0, 2'b10, 4'b1000, 1'b0});
    #1 turn_right = 1'b0;
    repeat (4) step();
    #1 power = 1'b0;
    step();
    chk("power_abort", {22'd0, state, moving_state, lights()}, {22'd0, 2'b01, 4'b0000, 4'b0000});
    #1 power = 1'b1; turn_right = 1'b1;
    repeat (3) step();
    chk("power_disarmed", {30'd0, state}, 32'd1);
    #1 turn_right = 1'b0;
    step();
    #1 turn_left = 1'b1;
    step();
    chk("rearm_left", {26'd0, state, moving_state}, {26'd0, 2'b10, 4'b0100});
    #1 turn_left = 1'b0;
    measure(2'b10, 50, n);
    chk("fresh_turn_len", n + 1, 12);

    // asynchronous reset in the middle of a cooldown
    step();
    #1 go_straight = 1'b1;
    step();
    chk("cool_again", {30'd0, state}, 32'd3);
    #1 go_straight = 1'b0;
    repeat (3) step();
    @(posedge sys_clk);
    #2 rst = 1'b0;
    #1 chk("async_reset", {22'd0, state, moving_state, lights()}, {22'd0, 2'b01, 4'b0000, 4'b0000});
    step(); step();
    #1 rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
